ipid_window_stats: RTL and testbench

IPID_WINDOW_STATS -- requirements
Module: ipid_window_stats

---
 rtl/ipid_window_stats_pkg.sv | 18 +
 rtl/ipid_window_stats_delta_accum.sv | 58 +++++
 rtl/ipid_window_stats.sv | 160 ++++++++++++++++
 tb/tb_ipid_window_stats.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ipid_window_stats_pkg.sv
// ---------------------------------------------------------------------------
// global_types -- shared types and helpers for the IP-ID window statistics
// block.
//   ipid_state_e : window FSM state (EMPTY = no previous ID held, ACCUM)
//   max()        : elaboration-time maximum, used for width calculations
// ---------------------------------------------------------------------------
package global_types;

    typedef enum logic {
        EMPTY = 1'b0,
        ACCUM = 1'b1
    } ipid_state_e;

    function automatic int unsigned max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ipid_window_stats_delta_accum.sv
// ---------------------------------------------------------------------------
// delta_accum -- running sum / max / min of ID deltas within one window.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   delta_i       : current delta (ID_BITS)
//   sample_i      : delta_i is a valid sample this cycle
//   restart_i     : return to the empty-window state (sum 0, max 0, min '1)
//   sum_o/max_o/min_o : running results *including* the current sample, so
//                   the parent can capture a completed window in the same
//                   cycle as its last delta.
// ---------------------------------------------------------------------------
module delta_accum #(
    parameter int unsigned ID_BITS = 16,
    parameter int unsigned SUM_W   = 21
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [ID_BITS-1:0] delta_i,
    input  logic               sample_i,
    input  logic               restart_i,
    output logic [SUM_W-1:0]   sum_o,
    output logic [ID_BITS-1:0] max_o,
    output logic [ID_BITS-1:0] min_o
);

    logic [SUM_W-1:0]   sum_q;
    logic [ID_BITS-1:0] max_q;
    logic [ID_BITS-1:0] min_q;

    always_comb begin
        sum_o = sum_q;
        max_o = max_q;
        min_o = min_q;
        if (sample_i) begin
            sum_o = sum_q + SUM_W'(delta_i);
            if (delta_i > max_q) max_o = delta_i;
            if (delta_i < min_q) min_o = delta_i;
        end
    end

    // restart wins over a coincident sample: that sample has already been
    // folded into the *_o values the parent captures this cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q <= '0;
            max_q <= '0;
            min_q <= '1;
        end else if (restart_i) begin
            sum_q <= '0;
            max_q <= '0;
            min_q <= '1;
        end else begin
            sum_q <= sum_o;
            max_q <= max_o;
            min_q <= min_o;
        end
    end

endmodule

// File: rtl/ipid_window_stats.sv
// ---------------------------------------------------------------------------
// ipid_window_stats -- statistics over contiguous windows of 2**LOG2_WIN
// IPv4 identification deltas (forward distance mod 2**ID_BITS).
//   sys_clk, reset_n : clock, asynchronous active-low reset
//   id_in, id_valid  : ID sample, one-cycle pulse per packet
//   clear            : synchronous restart, partial window discarded
//   sum_out, max_out, min_out, anom : results of last completed window
//   stats_valid      : one-cycle pulse when results are loaded
//   zero_cnt         : zero deltas in last window (only with
//                      IPID_STATS_ZERO_CNT_EN defined)
// ---------------------------------------------------------------------------
module ipid_window_stats
    import global_types::*;
#(
    parameter int unsigned        ID_BITS  = 16,
    parameter int unsigned        LOG2_WIN = 5,
    parameter logic [ID_BITS-1:0] THRESH   = 16'h0100
) (
    input  logic                        sys_clk,
    input  logic                        reset_n,
    input  logic [ID_BITS-1:0]          id_in,
    input  logic                        id_valid,
    input  logic                        clear,
    output logic [ID_BITS+LOG2_WIN-1:0] sum_out,
    output logic [ID_BITS-1:0]          max_out,
    output logic [ID_BITS-1:0]          min_out,
    output logic                        anom,
    output logic                        stats_valid
`ifdef IPID_STATS_ZERO_CNT_EN
    ,output logic [LOG2_WIN:0]          zero_cnt
`endif
);

    localparam int unsigned SUM_W    = ID_BITS + LOG2_WIN;
    localparam int unsigned CNT_W    = max(LOG2_WIN, 1);
    localparam int unsigned WIN_LAST = (2 ** LOG2_WIN) - 1;

    ipid_state_e        state_q, state_d;
    logic [ID_BITS-1:0] prev_id_q, prev_id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ID_BITS-1:0] delta;
    logic               accept;
    logic               first;
    logic               window_done;
    logic               acc_restart;

    logic [SUM_W-1:0]   acc_sum;
    logic [ID_BITS-1:0] acc_max;
    logic [ID_BITS-1:0] acc_min;

    logic [SUM_W-1:0]   sum_q;
    logic [ID_BITS-1:0] max_q;
    logic [ID_BITS-1:0] min_q;
    logic               anom_q;
    logic               stats_valid_q;

    // Unsigned subtraction wraps naturally: FFFF -> 0000 gives 1.
    assign delta = id_in - prev_id_q;

    always_comb begin
        state_d   = state_q;
        prev_id_d = prev_id_q;
        cnt_d     = cnt_q;
        accept    = 1'b0;
        first     = 1'b0;
        if (clear) begin
            state_d = EMPTY;
            cnt_d   = '0;
        end else if (id_valid) begin
            prev_id_d = id_in;
            unique case (state_q)
                EMPTY: begin
                    state_d = ACCUM;
                    first   = 1'b1;
                    cnt_d   = '0;
                end
                ACCUM: begin
                    accept = 1'b1;
                    cnt_d  = (cnt_q == CNT_W'(WIN_LAST)) ? '0 : cnt_q + CNT_W'(1);
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    assign window_done = accept && (cnt_q == CNT_W'(WIN_LAST));
    assign acc_restart = clear || first || window_done;

    delta_accum #(
        .ID_BITS (ID_BITS),
        .SUM_W   (SUM_W)
    ) u_accum (
        .clk_i     (sys_clk),
        .rst_ni    (reset_n),
        .delta_i   (delta),
        .sample_i  (accept),
        .restart_i (acc_restart),
        .sum_o     (acc_sum),
        .max_o     (acc_max),
        .min_o     (acc_min)
    );

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            prev_id_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            prev_id_q <= prev_id_d;
            cnt_q     <= cnt_d;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            sum_q         <= '0;
            max_q         <= '0;
            min_q         <= '0;
            anom_q        <= 1'b0;
            stats_valid_q <= 1'b0;
        end else begin
            stats_valid_q <= window_done;
            if (window_done) begin
                sum_q  <= acc_sum;
                max_q  <= acc_max;
                min_q  <= acc_min;
                anom_q <= (acc_max > THRESH);
            end
        end
    end

    assign sum_out     = sum_q;
    assign max_out     = max_q;
    assign min_out     = min_q;
    assign anom        = anom_q;
    assign stats_valid = stats_valid_q;

`ifdef IPID_STATS_ZERO_CNT_EN
    logic [LOG2_WIN:0] zc_run_q;
    logic [LOG2_WIN:0] zc_run_d;
    logic [LOG2_WIN:0] zero_cnt_q;

    assign zc_run_d = zc_run_q + (LOG2_WIN+1)'(accept && (delta == '0));

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            zc_run_q   <= '0;
            zero_cnt_q <= '0;
        end else begin
            zc_run_q <= acc_restart ? '0 : zc_run_d;
            if (window_done) zero_cnt_q <= zc_run_d;
        end
    end

    assign zero_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_ipid_window_stats.sv
module tb_ipid_window_stats;

    localparam int unsigned ID_BITS  = 16;
    localparam int unsigned LOG2_WIN = 2;

    logic                        sys_clk;
    logic                        reset_n;
    logic [ID_BITS-1:0]          id_in;
    logic                        id_valid;
    logic                        clear;
    logic [ID_BITS+LOG2_WIN-1:0] sum_out;
    logic [ID_BITS-1:0]          max_out;
    logic [ID_BITS-1:0]          min_out;
    logic                        anom;
    logic                        stats_valid;
`ifdef IPID_STATS_ZERO_CNT_EN
    logic [LOG2_WIN:0]           zero_cnt;
`endif

    ipid_window_stats #(
        .ID_BITS  (ID_BITS),
        .LOG2_WIN (LOG2_WIN),
        .THRESH   (16'h0100)
    ) dut (
        .sys_clk     (sys_clk),
        .reset_n     (reset_n),
        .id_in       (id_in),
        .id_valid    (id_valid),
        .clear       (clear),
        .sum_out     (sum_out),
        .max_out     (max_out),
        .min_out     (min_out),
        .anom        (anom),
        .stats_valid (stats_valid)
`ifdef IPID_STATS_ZERO_CNT_EN
        ,.zero_cnt   (zero_cnt)
`endif
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [31:0] sum;
        logic [31:0] mx;
        logic [31:0] mn;
        logic [31:0] an;
        logic [31:0] zc;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [31:0] s, input logic [31:0] mx,
                            input logic [31:0] mn, input logic [31:0] an,
                            input logic [31:0] zc);
        exp_t e;
        e.sum = s; e.mx = mx; e.mn = mn; e.an = an; e.zc = zc;
        exp_q.push_back(e);
    endtask

    task automatic send_id(input logic [ID_BITS-1:0] v);
        id_in    = v;
        id_valid = 1'b1;
        @(negedge sys_clk);
        id_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge sys_clk);
        clear = 1'b0;
    endtask

    task automatic check_outputs(input string tag, input logic [31:0] s,
                                 input logic [31:0] mx, input logic [31:0] mn,
                                 input logic [31:0] an);
        check({tag, "_sum"},  32'(sum_out), s);
        check({tag, "_max"},  32'(max_out), mx);
        check({tag, "_min"},  32'(min_out), mn);
        check({tag, "_anom"}, 32'(anom), an);
        check({tag, "_stats_valid"}, 32'(stats_valid), 32'd0);
`ifdef IPID_STATS_ZERO_CNT_EN
        check({tag, "_zero_cnt"}, 32'(zero_cnt), 32'd0);
`endif
    endtask

    // Scoreboard monitor: every stats_valid pulse must match the oldest
    // outstanding expectation.
    always @(negedge sys_clk) begin
        if (reset_n && stats_valid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_stats_valid: got sum=%0h max=%0h min=%0h, expected no report",
                         sum_out, max_out, min_out);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("win_sum",  32'(sum_out), e.sum);
                check("win_max",  32'(max_out), e.mx);
                check("win_min",  32'(min_out), e.mn);
                check("win_anom", 32'(anom),    e.an);
`ifdef IPID_STATS_ZERO_CNT_EN
                check("win_zero_cnt", 32'(zero_cnt), e.zc);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n  = 1'b0;
        id_in    = '0;
        id_valid = 1'b0;
        clear    = 1'b0;
        repeat (2) @(negedge sys_clk);
        check_outputs("reset", 32'd0, 32'd0, 32'd0, 32'd0);
        reset_n = 1'b1;
        @(negedge sys_clk);

        // basic window
        push_exp(32'd4, 32'd1, 32'd1, 32'd0, 32'd0);
        send_id(16'd10); send_id(16'd11); send_id(16'd12); send_id(16'd13); send_id(16'd14);
        do_clear();

        // wrap FFFF -> 0000
        push_exp(32'd4, 32'd1, 32'd1, 32'd0, 32'd0);
        send_id(16'hFFFE); send_id(16'hFFFF); send_id(16'h0000); send_id(16'h0001); send_id(16'h0002);
        do_clear();

        // max exactly at threshold: no anomaly
        push_exp(32'h103, 32'h100, 32'd1, 32'd0, 32'd0);
        send_id(16'h0000); send_id(16'h0100); send_id(16'h0101); send_id(16'h0102); send_id(16'h0103);
        do_clear();

        // above threshold: anomaly
        push_exp(32'h301, 32'h2FE, 32'd1, 32'd1, 32'd0);
        send_id(16'h0000); send_id(16'h0001); send_id(16'h0002); send_id(16'h0300); send_id(16'h0301);
        do_clear();

        // clear with coincident id_valid discards partial window
        send_id(16'd1); send_id(16'd2); send_id(16'd3);
        clear = 1'b1;
        send_id(16'd4);
        clear = 1'b0;
        repeat (3) @(negedge sys_clk);
        check("held_sum",  32'(sum_out), 32'h301);
        check("held_max",  32'(max_out), 32'h2FE);
        check("held_min",  32'(min_out), 32'd1);
        check("held_anom", 32'(anom),    32'd1);
        push_exp(32'd8, 32'd2, 32'd2, 32'd0, 32'd0);
        send_id(16'd20); send_id(16'd22); send_id(16'd24); send_id(16'd26); send_id(16'd28);
        do_clear();

        // back-to-back windows; first ID of window 2 arrives with stats_valid
        push_exp(32'd10, 32'd4, 32'd1, 32'd0, 32'd0);
        push_exp(32'd7,  32'd2, 32'd1, 32'd0, 32'd0);
        send_id(16'd100); send_id(16'd101); send_id(16'd103); send_id(16'd106); send_id(16'd110);
        send_id(16'd111); send_id(16'd113); send_id(16'd115); send_id(16'd117);
        do_clear();

        // repeated IDs: zero deltas
        push_exp(32'd1, 32'd1, 32'd0, 32'd0, 32'd3);
        send_id(16'd5); send_id(16'd5); send_id(16'd5); send_id(16'd6); send_id(16'd6);
        do_clear();

        // reset mid-window
        send_id(16'd1); send_id(16'd2); send_id(16'd3);
        reset_n = 1'b0;
        #1;
        check_outputs("midreset", 32'd0, 32'd0, 32'd0, 32'd0);
        @(negedge sys_clk);
        reset_n = 1'b1;
        @(negedge sys_clk);
        send_id(16'd5); send_id(16'd6); send_id(16'd7); send_id(16'd8);
        repeat (3) @(negedge sys_clk);
        check("post_reset_no_report", 32'(exp_q.size()), 32'd0);
        push_exp(32'd4, 32'd1, 32'd1, 32'd0, 32'd0);
        send_id(16'd9);

        repeat (3) @(negedge sys_clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
